// File: rtl/bsg_axi_pkg.sv
// Shared AXI helper types for the bsg AXI blocks.
// Burst encoding, read-arbiter state encoding and a width helper.
package bsg_axi_pkg;

    typedef enum logic [1:0] {
        e_axi_burst_fixed = 2'b00,
        e_axi_burst_incr  = 2'b01,
        e_axi_burst_wrap  = 2'b10
    } bsg_axi_burst_type_e;

    typedef enum logic [1:0] {
        e_rd_arb_idle,
        e_rd_arb_addr,
        e_rd_arb_data
    } bsg_axi_rd_arb_state_e;

    // Never returns 0, so the result is always usable as a vector width.
    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x < 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_rr_select.sv
// Round-robin picker: first set request at or above ptr_i, wrapping to the
// lowest set request when nothing at or above the pointer is pending.
module bsg_rr_select
    import bsg_axi_pkg::*;
#(
    parameter int unsigned width_p = 2,
    localparam int unsigned lg_width_lp = safe_clog2(width_p)
) (
    input  logic [width_p-1:0]     reqs_i,
    input  logic [lg_width_lp-1:0] ptr_i,
    output logic                   v_o,
    output logic [lg_width_lp-1:0] idx_o
);

    logic [width_p-1:0] mask;
    logic [width_p-1:0] masked;

    always_comb begin
        mask = '0;
        for (int i = 0; i < width_p; i++) begin
            mask[i] = (32'(i) >= 32'(ptr_i));
        end
    end

    assign masked = reqs_i & mask;
    assign v_o    = |reqs_i;

    // Descending scans leave the lowest set index; the masked scan wins if it finds any.
    always_comb begin
        idx_o = '0;
        for (int i = width_p - 1; i >= 0; i--) begin
            if (reqs_i[i]) idx_o = lg_width_lp'(i);
        end
        for (int i = width_p - 1; i >= 0; i--) begin
            if (masked[i]) idx_o = lg_width_lp'(i);
        end
    end

endmodule

// File: rtl/bsg_axi_rd_arbiter.sv
// Shares one AXI4 read channel (AR + R) between several requesters, one
// burst in flight at a time, round-robin grant per transaction.
module bsg_axi_rd_arbiter
    import bsg_axi_pkg::*;
#(
    parameter int unsigned num_masters_p    = 2,
    parameter int unsigned axi_id_width_p   = 6,
    parameter int unsigned axi_addr_width_p = 64,
    parameter int unsigned axi_data_width_p = 64,
    parameter int unsigned axi_burst_len_p  = 2,
    localparam int unsigned lg_masters_lp   = safe_clog2(num_masters_p)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,

    input  logic [num_masters_p*axi_id_width_p-1:0]   s_arid_i,
    input  logic [num_masters_p*axi_addr_width_p-1:0] s_araddr_i,
    input  logic [num_masters_p*2-1:0]                s_arburst_i,
    input  logic [num_masters_p-1:0]                  s_arvalid_i,
    output logic [num_masters_p-1:0]                  s_arready_o,

    output logic [axi_id_width_p-1:0]                 s_rid_o,
    output logic [axi_data_width_p-1:0]               s_rdata_o,
    output logic [1:0]                                s_rresp_o,
    output logic                                      s_rlast_o,
    output logic [num_masters_p-1:0]                  s_rvalid_o,
    input  logic [num_masters_p-1:0]                  s_rready_i,

    output logic [axi_id_width_p-1:0]                 m_arid_o,
    output logic [axi_addr_width_p-1:0]               m_araddr_o,
    output logic [1:0]                                m_arburst_o,
    output logic                                      m_arvalid_o,
    input  logic                                      m_arready_i,

    input  logic [axi_id_width_p-1:0]                 m_rid_i,
    input  logic [axi_data_width_p-1:0]               m_rdata_i,
    input  logic [1:0]                                m_rresp_i,
    input  logic                                      m_rlast_i,
    input  logic                                      m_rvalid_i,
    output logic                                      m_rready_o,

    output logic [lg_masters_lp-1:0]                  grant_idx_o,
    output logic                                      busy_o,
    output logic                                      len_err_o
);

    if (num_masters_p < 2) begin : g_bad_masters
        $error("bsg_axi_rd_arbiter needs num_masters_p >= 2");
    end
    if (axi_burst_len_p < 1) begin : g_bad_len
        $error("bsg_axi_rd_arbiter needs axi_burst_len_p >= 1");
    end

    // One spare bit so the counter can saturate past the expected last beat.
    localparam int unsigned cnt_width_lp = safe_clog2(axi_burst_len_p) + 1;
    localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(axi_burst_len_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = '1;

    bsg_axi_rd_arb_state_e state_q, state_d;

    logic [lg_masters_lp-1:0] grant_q, grant_d;
    logic [lg_masters_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [cnt_width_lp-1:0]  beat_cnt_q, beat_cnt_d;
    logic                     len_err_q, len_err_d;

    logic                     sel_v;
    logic [lg_masters_lp-1:0] sel_idx;
    logic                     ar_hs;
    logic                     r_hs;

    bsg_rr_select #(
        .width_p (num_masters_p)
    ) u_rr_select (
        .reqs_i (s_arvalid_i),
        .ptr_i  (rr_ptr_q),
        .v_o    (sel_v),
        .idx_o  (sel_idx)
    );

    assign ar_hs = (state_q == e_rd_arb_addr) & s_arvalid_i[grant_q] & m_arready_i;
    assign r_hs  = (state_q == e_rd_arb_data) & m_rvalid_i & s_rready_i[grant_q];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_rd_arb_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_rd_arb_idle: if (sel_v) state_d = e_rd_arb_addr;
            e_rd_arb_addr: if (ar_hs) state_d = e_rd_arb_data;
            e_rd_arb_data: if (r_hs && m_rlast_i) state_d = e_rd_arb_idle;
            default:       state_d = e_rd_arb_idle;
        endcase
    end

    always_comb begin
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;

        if ((state_q == e_rd_arb_idle) && sel_v) begin
            grant_d = sel_idx;
        end

        if (ar_hs) begin
            beat_cnt_d = '0;
        end

        if (r_hs) begin
            if (beat_cnt_q != cnt_max_lp) beat_cnt_d = beat_cnt_q + 1'b1;
            // Flags both an early rlast and a missing rlast on the expected last beat.
            if (m_rlast_i != (beat_cnt_q == last_beat_lp)) len_err_d = 1'b1;
            if (m_rlast_i) begin
                rr_ptr_d = (32'(grant_q) == num_masters_p - 1) ? '0 : grant_q + 1'b1;
            end
        end
    end

    always_comb begin
        s_arready_o = '0;
        s_rvalid_o  = '0;
        m_arvalid_o = 1'b0;
        m_rready_o  = 1'b0;
        unique case (state_q)
            e_rd_arb_addr: begin
                m_arvalid_o          = s_arvalid_i[grant_q];
                s_arready_o[grant_q] = m_arready_i;
            end
            e_rd_arb_data: begin
                s_rvalid_o[grant_q] = m_rvalid_i;
                m_rready_o          = s_rready_i[grant_q];
            end
            default: ;
        endcase
    end

    assign m_arid_o    = s_arid_i[32'(grant_q)*axi_id_width_p +: axi_id_width_p];
    assign m_araddr_o  = s_araddr_i[32'(grant_q)*axi_addr_width_p +: axi_addr_width_p];
    assign m_arburst_o = s_arburst_i[32'(grant_q)*2 +: 2];

    assign s_rid_o   = m_rid_i;
    assign s_rdata_o = m_rdata_i;
    assign s_rresp_o = m_rresp_i;
    assign s_rlast_o = m_rlast_i;

    assign grant_idx_o = grant_q;
    assign busy_o      = (state_q != e_rd_arb_idle);
    assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_bsg_axi_rd_arbiter.sv
// Directed bench for bsg_axi_rd_arbiter with a transaction-level reference
// model checked every cycle, plus literal expectations per scenario.
module tb_bsg_axi_rd_arbiter;

    localparam int N   = 2;
    localparam int IDW = 6;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int L   = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [N*IDW-1:0] s_arid = '0;
    logic [N*AW-1:0] s_araddr = '0;
    logic [N*2-1:0]  s_arburst = '0;
    logic [N-1:0]    s_arvalid = '0;
    logic [N-1:0]    s_arready;
    logic [IDW-1:0]  s_rid;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready = '0;
    logic [IDW-1:0]  m_arid;
    logic [AW-1:0]   m_araddr;
    logic [1:0]      m_arburst;
    logic            m_arvalid;
    logic            m_arready = 1'b0;
    logic [IDW-1:0]  m_rid = '0;
    logic [DW-1:0]   m_rdata = '0;
    logic [1:0]      m_rresp = '0;
    logic            m_rlast = 1'b0;
    logic            m_rvalid = 1'b0;
    logic            m_rready;
    logic            grant_idx;
    logic            busy;
    logic            len_err;

    int tests = 0;
    int fails = 0;

    bsg_axi_rd_arbiter #(
        .num_masters_p    (N),
        .axi_id_width_p   (IDW),
        .axi_addr_width_p (AW),
        .axi_data_width_p (DW),
        .axi_burst_len_p  (L)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .s_arid_i    (s_arid),
        .s_araddr_i  (s_araddr),
        .s_arburst_i (s_arburst),
        .s_arvalid_i (s_arvalid),
        .s_arready_o (s_arready),
        .s_rid_o     (s_rid),
        .s_rdata_o   (s_rdata),
        .s_rresp_o   (s_rresp),
        .s_rlast_o   (s_rlast),
        .s_rvalid_o  (s_rvalid),
        .s_rready_i  (s_rready),
        .m_arid_o    (m_arid),
        .m_araddr_o  (m_araddr),
        .m_arburst_o (m_arburst),
        .m_arvalid_o (m_arvalid),
        .m_arready_i (m_arready),
        .m_rid_i     (m_rid),
        .m_rdata_i   (m_rdata),
        .m_rresp_i   (m_rresp),
        .m_rlast_i   (m_rlast),
        .m_rvalid_i  (m_rvalid),
        .m_rready_o  (m_rready),
        .grant_idx_o (grant_idx),
        .busy_o      (busy),
        .len_err_o   (len_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: phase 0 = no transaction, 1 = address offered, 2 = burst streaming.
    int mdl_phase = 0;
    int mdl_grant = 0;
    int mdl_next  = 0;
    int mdl_beats = 0;
    bit mdl_err   = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdl_phase = 0;
            mdl_grant = 0;
            mdl_next  = 0;
            mdl_beats = 0;
            mdl_err   = 0;
        end else if (mdl_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                if (s_arvalid[(mdl_next + k) % N]) begin
                    mdl_grant = (mdl_next + k) % N;
                    mdl_phase = 1;
                    break;
                end
            end
        end else if (mdl_phase == 1) begin
            if (s_arvalid[mdl_grant] && m_arready) begin
                mdl_phase = 2;
                mdl_beats = 0;
            end
        end else if (m_rvalid && s_rready[mdl_grant]) begin
            mdl_beats++;
            if (m_rlast && mdl_beats != L) mdl_err = 1;
            if (!m_rlast && mdl_beats == L) mdl_err = 1;
            if (m_rlast) begin
                mdl_phase = 0;
                mdl_next  = (mdl_grant + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_arready;
        logic [N-1:0] e_rvalid;
        e_arready = '0;
        e_rvalid  = '0;
        if (mdl_phase == 1) e_arready[mdl_grant] = m_arready;
        if (mdl_phase == 2) e_rvalid[mdl_grant] = m_rvalid;
        chk("busy", 64'(busy), 64'(mdl_phase != 0));
        chk("grant_idx", 64'(grant_idx), 64'(mdl_grant));
        chk("len_err", 64'(len_err), 64'(mdl_err));
        chk("s_arready", 64'(s_arready), 64'(e_arready));
        chk("s_rvalid", 64'(s_rvalid), 64'(e_rvalid));
        chk("m_arvalid", 64'(m_arvalid), 64'(mdl_phase == 1 && s_arvalid[mdl_grant]));
        chk("m_rready", 64'(m_rready), 64'(mdl_phase == 2 && s_rready[mdl_grant]));
        if (mdl_phase == 1) begin
            chk("m_araddr", m_araddr, s_araddr[mdl_grant*AW +: AW]);
            chk("m_arid", 64'(m_arid), 64'(s_arid[mdl_grant*IDW +: IDW]));
            chk("m_arburst", 64'(m_arburst), 64'(s_arburst[mdl_grant*2 +: 2]));
        end
        if (mdl_phase == 2) begin
            chk("s_rdata", s_rdata, m_rdata);
            chk("s_rlast", 64'(s_rlast), 64'(m_rlast));
            chk("s_rid", 64'(s_rid), 64'(m_rid));
        end
    end

    // Beats actually delivered to each requester, and grant order at AR acceptance.
    logic [63:0] rx0 [$];
    logic [63:0] rx1 [$];
    int          grants [$];

    always @(posedge clk) begin
        if (s_rvalid[0] && s_rready[0]) rx0.push_back(s_rdata);
        if (s_rvalid[1] && s_rready[1]) rx1.push_back(s_rdata);
        if (m_arvalid && m_arready) grants.push_back(int'(grant_idx));
    end

    task automatic clear_logs();
        rx0.delete();
        rx1.delete();
        grants.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the AR handshake edge; an expired bound counts as a failure.
    task automatic wait_ar();
        bit ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_arvalid && m_arready) begin
                ok = 1;
                break;
            end
        end
        chk("ar_handshake_seen", 64'(ok), 64'(1));
        step();
    endtask

    task automatic drive_beat(input logic [63:0] d, input bit last);
        bit ok = 0;
        m_rvalid = 1'b1;
        m_rdata  = d;
        m_rlast  = last;
        m_rid    = d[IDW-1:0];
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ok = m_rready;
            step();
            if (ok) break;
        end
        chk("r_handshake_seen", 64'(ok), 64'(1));
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp0 [4];
        logic [63:0] exp1 [4];
        int          exp_g [4];
        bit          pat [4];
        int          b;

        // Reset with busy-looking inputs: every valid/ready output must stay low.
        #3 reset_n = 1'b0;
        s_arvalid = '1;
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
        s_rready  = '1;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_len_err", 64'(len_err), 64'(0));
        chk("rst_grant", 64'(grant_idx), 64'(0));
        chk("rst_m_arvalid", 64'(m_arvalid), 64'(0));
        chk("rst_m_rready", 64'(m_rready), 64'(0));
        chk("rst_s_rvalid", 64'(s_rvalid), 64'(0));
        chk("rst_s_arready", 64'(s_arready), 64'(0));
        #15;
        s_arvalid = '0;
        m_rvalid  = 1'b0;
        s_rready  = '0;
        s_arid    = {6'h2A, 6'h05};
        s_arburst = {2'b01, 2'b01};
        #4 reset_n = 1'b1;
        step();

        // Single request from requester 1.
        clear_logs();
        s_araddr[1*AW +: AW] = 64'h40;
        s_arvalid = 2'b10;
        m_arready = 1'b1;
        s_rready  = 2'b11;
        #1;
        chk("single_idle_arvalid", 64'(m_arvalid), 64'(0));
        step();
        chk("single_araddr", m_araddr, 64'h40);
        chk("single_arvalid", 64'(m_arvalid), 64'(1));
        chk("single_grant", 64'(grant_idx), 64'(1));
        step();
        s_arvalid = '0;
        drive_beat(64'hA, 1'b0);
        drive_beat(64'hB, 1'b1);
        chk("single_rx1_n", 64'(rx1.size()), 64'(2));
        chk("single_rx1_0", rx1[0], 64'hA);
        chk("single_rx1_1", rx1[1], 64'hB);
        chk("single_rx0_n", 64'(rx0.size()), 64'(0));
        chk("single_idle_after", 64'(busy), 64'(0));

        // Contention: both requesters pending continuously.
        clear_logs();
        s_araddr[0*AW +: AW] = 64'h1000;
        s_araddr[1*AW +: AW] = 64'h2000;
        s_arvalid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_ar();
            drive_beat(64'h100 + 64'(2*t), 1'b0);
            drive_beat(64'h101 + 64'(2*t), 1'b1);
        end
        s_arvalid = '0;
        exp_g = '{0, 1, 0, 1};
        exp0  = '{64'h100, 64'h101, 64'h104, 64'h105};
        exp1  = '{64'h102, 64'h103, 64'h106, 64'h107};
        chk("cont_grants_n", 64'(grants.size()), 64'(4));
        chk("cont_rx0_n", 64'(rx0.size()), 64'(4));
        chk("cont_rx1_n", 64'(rx1.size()), 64'(4));
        for (int t = 0; t < 4; t++) begin
            chk("cont_grant", 64'(grants[t]), 64'(exp_g[t]));
            chk("cont_rx0", rx0[t], exp0[t]);
            chk("cont_rx1", rx1[t], exp1[t]);
        end

        // Backpressure: requester 0 rready 1,0,0,1; requester 1 rready driven opposite.
        clear_logs();
        s_araddr[0*AW +: AW] = 64'h3000;
        s_arvalid = 2'b01;
        wait_ar();
        s_arvalid = '0;
        pat = '{1, 0, 0, 1};
        b = 0;
        for (int c = 0; c < 4; c++) begin
            s_rready = {~pat[c], pat[c]};
            m_rvalid = 1'b1;
            m_rdata  = 64'h10 + 64'(b);
            m_rlast  = (b == 1);
            @(negedge clk);
            chk("bp_m_rready", 64'(m_rready), 64'(pat[c]));
            step();
            if (pat[c]) b++;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = 2'b11;
        #1;
        chk("bp_rx0_n", 64'(rx0.size()), 64'(2));
        chk("bp_rx0_0", rx0[0], 64'h10);
        chk("bp_rx0_1", rx0[1], 64'h11);
        chk("bp_rx1_n", 64'(rx1.size()), 64'(0));
        chk("bp_len_err", 64'(len_err), 64'(0));
        chk("bp_busy", 64'(busy), 64'(0));

        // Length error: rlast on the first beat of a two-beat burst.
        s_arvalid = 2'b10;
        wait_ar();
        s_arvalid = '0;
        drive_beat(64'h20, 1'b1);
        chk("lerr_set", 64'(len_err), 64'(1));
        chk("lerr_idle", 64'(busy), 64'(0));
        step();
        step();
        chk("lerr_sticky", 64'(len_err), 64'(1));

        // Slave AR stall for five cycles.
        s_araddr[0*AW +: AW] = 64'h80;
        m_arready = 1'b0;
        s_arvalid = 2'b01;
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_arvalid", 64'(m_arvalid), 64'(1));
            chk("stall_araddr", m_araddr, 64'h80);
            chk("stall_s_arready", 64'(s_arready), 64'(0));
            step();
        end
        m_arready = 1'b1;
        #1;
        chk("stall_release_arready", 64'(s_arready), 64'(2'b01));
        step();
        s_arvalid = '0;
        drive_beat(64'h30, 1'b0);
        drive_beat(64'h31, 1'b1);
        chk("stall_len_err_kept", 64'(len_err), 64'(1));

        // Async reset in the middle of a burst.
        s_arvalid = 2'b01;
        wait_ar();
        s_arvalid = '0;
        m_rvalid  = 1'b1;
        m_rdata   = 64'h55;
        s_rready  = 2'b11;
        #1;
        chk("arst_pre_rvalid", 64'(s_rvalid), 64'(2'b01));
        chk("arst_pre_len_err", 64'(len_err), 64'(1));
        #1 reset_n = 1'b0;
        #1;
        chk("arst_s_rvalid", 64'(s_rvalid), 64'(0));
        chk("arst_m_rready", 64'(m_rready), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_len_err", 64'(len_err), 64'(0));
        @(negedge clk);
        #1;
        m_rvalid = 1'b0;
        #1 reset_n = 1'b1;
        step();

        // Normal service after reset.
        clear_logs();
        s_araddr[1*AW +: AW] = 64'h200;
        s_arvalid = 2'b10;
        wait_ar();
        s_arvalid = '0;
        drive_beat(64'h60, 1'b0);
        drive_beat(64'h61, 1'b1);
        chk("post_grant_n", 64'(grants.size()), 64'(1));
        chk("post_grant", 64'(grants[0]), 64'(1));
        chk("post_rx1_n", 64'(rx1.size()), 64'(2));
        chk("post_rx1_0", rx1[0], 64'h60);
        chk("post_rx1_1", rx1[1], 64'h61);
        chk("post_len_err", 64'(len_err), 64'(0));

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_axi_rd_arbiter.md
Name: bsg_axi_rd_arbiter

Overview:
Shares one AXI4 read channel (AR + R) of a single slave, e.g. the nonsynth AXI memory model, between num_masters_p requesters. Round-robin grant per transaction. The grant is held from AR acceptance until the R beat carrying rlast completes, so only one burst is outstanding at a time. Sits between requester-side AXI read masters and the shared slave port in testbenches and simple memory subsystems.

Parameters:
num_masters_p, 2, number of requesters (>=2)
axi_id_width_p, 6, ARID/RID width
axi_addr_width_p, 64, ARADDR width
axi_data_width_p, 64, RDATA width
axi_burst_len_p, 2, beats per burst expected on every read
lg_masters_lp, `BSG_SAFE_CLOG2(num_masters_p), derived, grant index width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, asynchronous, active-low
s_arid_i  in  num_masters_p*axi_id_width_p  per-requester ARID, requester i at slice i
s_araddr_i  in  num_masters_p*axi_addr_width_p  per-requester ARADDR
s_arburst_i  in  num_masters_p*2  per-requester ARBURST
s_arvalid_i  in  num_masters_p  per-requester ARVALID
s_arready_o  out  num_masters_p  per-requester ARREADY
s_rid_o  out  axi_id_width_p  broadcast RID
s_rdata_o  out  axi_data_width_p  broadcast RDATA
s_rresp_o  out  2  broadcast RRESP
s_rlast_o  out  1  broadcast RLAST
s_rvalid_o  out  num_masters_p  RVALID, asserted only to the granted requester
s_rready_i  in  num_masters_p  per-requester RREADY
m_arid_o  out  axi_id_width_p  to slave
m_araddr_o  out  axi_addr_width_p  to slave
m_arburst_o  out  2  to slave
m_arvalid_o  out  1  to slave
m_arready_i  in  1  from slave
m_rid_i  in  axi_id_width_p  from slave
m_rdata_i  in  axi_data_width_p  from slave
m_rresp_i  in  2  from slave
m_rlast_i  in  1  from slave
m_rvalid_i  in  1  from slave
m_rready_o  out  1  to slave
grant_idx_o  out  lg_masters_lp  current or last grant index
busy_o  out  1  high in ADDR or DATA state
len_err_o  out  1  sticky: rlast seen at wrong beat count

Behaviour:
- Async reset (reset_n_i low): state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, len_err_o=0. All valid and ready outputs are 0 immediately, with no clock required. Reset mid-burst abandons the burst and does not drain it.
- States:
  - IDLE: all s_arready_o, s_rvalid_o, m_arvalid_o and m_rready_o are 0. If any s_arvalid_i is high, pick the first set bit searching from rr_ptr upward with wrap, register it in grant, go to ADDR. Otherwise stay.
  - ADDR: m_ar* = the granted requester's slice. m_arvalid_o = s_arvalid_i[grant]. s_arready_o[grant] = m_arready_i; all others 0. On m_arvalid_o & m_arready_i: beat_cnt<=0, go to DATA.
  - DATA: s_r* = m_r*. s_rvalid_o[grant] = m_rvalid_i; all others 0. m_rready_o = s_rready_i[grant]. On each beat (m_rvalid_i & m_rready_o): beat_cnt++.
  - Leaving DATA: on a beat with m_rlast_i, go to IDLE and set rr_ptr <= grant+1, wrapping to 0 past num_masters_p-1.
- Length check: on an rlast beat with beat_cnt != axi_burst_len_p-1, set len_err_o and keep it set until reset. A beat with beat_cnt == axi_burst_len_p-1 but no rlast also sets len_err_o. The state still waits for rlast.
- Latency: a request arriving in IDLE reaches m_arvalid_o on the next cycle (one registered arbitration cycle). R-path pass-through is purely combinational, with zero latency.
- Back-to-back: IDLE takes at least one cycle between bursts. A requester still asserting arvalid loses priority to any other pending requester.
- Requesters must hold arvalid once asserted (AXI rule). Withdrawal in ADDR just stalls; no error is flagged.
- IDs pass through unmodified; RID is not checked.
- grant_idx_o = grant register. busy_o = (state != IDLE).

Decomposition:
- State enum {e_rd_arb_idle, e_rd_arb_addr, e_rd_arb_data} goes in bsg_axi_pkg, beside the existing burst-type enum.
- Round-robin selection (mask from rr_ptr, priority-encode with wrap) goes in one sub-module: bsg_rr_select (reqs_i, ptr_i -> v_o, idx_o).

Test Plan:
- Single request: requester 1 issues arvalid, addr=0x40; slave arready=1, two beats 0xA, 0xB, rlast on beat 1 -> m_araddr_o=0x40 one cycle after arvalid. Requester 1 sees both beats. s_rvalid_o[0]=0 throughout. rr_ptr=0 afterwards (1+1 wraps for N=2).
- Contention: both requesters assert from reset release -> grants in order 0,1,0,1 over four bursts. grant_idx_o follows that order. No beat reaches the wrong requester.
- Backpressure: granted requester's rready toggles 1,0,0,1 -> m_rready_o mirrors it. beat_cnt advances only on handshake cycles. Data stays intact.
- Length error: slave asserts rlast on beat 0 with burst_len_p=2 -> len_err_o=1 from the next cycle onward. FSM returns to IDLE. The flag stays set until reset_n_i is driven low.
- Async reset mid-DATA: drive reset_n_i low between clock edges -> s_rvalid_o, m_rready_o and busy_o go to 0 in the same time step. After release, a new request is served normally.
- Slave AR stall: m_arready_i=0 for 5 cycles -> m_arvalid_o stays high with a stable address. The granted s_arready_o stays 0 until m_arready_i rises.
